// File: rtl/gen_gamma_coder_stream.sv
// ---------------------------------------------------------------------------
// gen_gamma_coder_stream
//
// Streaming gamma coder. A seedable Galois LFSR produces the keystream.
// Encode adds the current key to the input word. Decode subtracts a supplied
// key and reports a borrow. Each transfer passes through IDLE -> CALC -> HOLD,
// and HOLD acts as the single-entry output buffer.
//
// Parameters:
//   DW       data/key width (>= 4)
//   POLY     Galois feedback mask, DW bits
//   SEED_RST LFSR reset value (non-zero)
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   en                  free-run LFSR step enable
//   seed_load, seed     reload the LFSR (a zero seed loads 1)
//   mode                0 = encode, 1 = decode; sampled on accept
//   in_valid/in_ready   input handshake
//   in_data [DW:0]      encode: low DW bits used; decode: mixed word
//   in_key  [DW-1:0]    decode key
//   out_valid/out_ready output handshake
//   out_data [DW:0]     mixed / recovered word
//   out_key [DW-1:0]    key used for the word
//   out_err             decode borrow
//   busy                state != IDLE
//   word_cnt [15:0]     completed-transfer count
//
// Optional feature macro: GAMMA_CODER_STATS_EN
//   When it is defined, word_cnt counts out_valid && out_ready and wraps.
//   When it is undefined, word_cnt is constant zero.
// ---------------------------------------------------------------------------
module gen_gamma_coder_stream #(
    parameter int unsigned          DW       = 8,
    parameter logic [DW-1:0]        POLY     = 8'hB8,
    parameter logic [DW-1:0]        SEED_RST = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          seed_load,
    input  logic [DW-1:0] seed,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW:0]   in_data,
    input  logic [DW-1:0] in_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW:0]   out_data,
    output logic [DW-1:0] out_key,
    output logic          out_err,
    output logic          busy,
    output logic [15:0]   word_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] lfsr_q;
    logic [DW-1:0] lfsr_step;
    logic [DW:0]   data_q;
    logic [DW-1:0] key_q;
    logic          mode_q;
    logic          accept;
    logic          enc_accept;
    logic          xfer_done;
    logic [DW:0]   enc_sum;
    logic [DW+1:0] dec_diff;

    // The LFSR stays internal. It is observable only through the encode key.
    assign lfsr_step  = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);

    // When seed_load is high it takes priority, so it also blocks an accept.
    assign in_ready   = (state_q == IDLE) && !seed_load;
    assign accept     = in_valid && in_ready;
    assign enc_accept = accept && !mode;
    assign out_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign xfer_done  = out_valid && out_ready;

    // Encode never borrows. The carry lands in the extra MSB.
    assign enc_sum  = {1'b0, data_q[DW-1:0]} + {1'b0, key_q};
    // Decode uses one extra bit so that the top bit captures the borrow.
    assign dec_diff = {1'b0, data_q} - {2'b00, key_q};

    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples pre-edge values, whatever order the always blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_RST;
        end else if (seed_load) begin
            lfsr_q <= (seed == '0) ? DW'(1) : seed;
        end else if (en || enc_accept) begin
            lfsr_q <= lfsr_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default first, so every path assigns it and no
    // latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = CALC;
            CALC:                   state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // NOTE: the capture and output registers are reset as well. The outputs
    // have defined reset values, and a reset mid-word must drop the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            key_q    <= '0;
            mode_q   <= 1'b0;
            out_data <= '0;
            out_key  <= '0;
            out_err  <= 1'b0;
        end else begin
            if (accept) begin
                data_q <= in_data;
                key_q  <= mode ? in_key : lfsr_q;
                mode_q <= mode;
            end
            if (state_q == CALC) begin
                out_key <= key_q;
                if (mode_q) begin
                    out_data <= dec_diff[DW:0];
                    out_err  <= dec_diff[DW+1];
                end else begin
                    out_data <= enc_sum;
                    out_err  <= 1'b0;
                end
            end
        end
    end

`ifdef GAMMA_CODER_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (xfer_done) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign word_cnt = cnt_q;
`else
    assign word_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_gen_gamma_coder_stream.sv
// ---------------------------------------------------------------------------
// tb_gen_gamma_coder_stream
//
// Directed bench for gen_gamma_coder_stream with DW=8, POLY=8'hB8, SEED_RST=1.
// The expected keys come from stepping the LFSR by hand:
//   5A->2D->AE, 01->B8->5C, 33->A1->E8, 77->83.
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_gen_gamma_coder_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        seed_load;
    logic [7:0]  seed;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_data;
    logic [7:0]  in_key;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_data;
    logic [7:0]  out_key;
    logic        out_err;
    logic        busy;
    logic [15:0] word_cnt;

    int errors = 0;
    int checks = 0;
    int xfers  = 0;

    always #5 clk = ~clk;

    gen_gamma_coder_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .seed_load (seed_load),
        .seed      (seed),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_key   (out_key),
        .out_err   (out_err),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wc_exp();
`ifdef GAMMA_CODER_STATS_EN
        return 16'(xfers);
`else
        return 16'h0000;
`endif
    endfunction

    // One complete transfer with out_ready high. It checks the latency
    // (not valid at t+1, valid at t+2), the outputs, the return to IDLE,
    // and that the outputs are held after the transfer.
    task automatic xfer(input logic m, input logic [8:0] d, input logic [7:0] k,
                        input logic [8:0] ed, input logic [7:0] ek, input logic ee,
                        input string tag);
        @(negedge clk);
        check({tag, ".in_ready"}, in_ready, 1'b1);
        mode     = m;
        in_data  = d;
        in_key   = k;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".t1_valid"}, out_valid, 1'b0);
        check({tag, ".t1_busy"}, busy, 1'b1);
        @(negedge clk);
        check({tag, ".t2_valid"}, out_valid, 1'b1);
        check({tag, ".data"}, out_data, ed);
        check({tag, ".key"}, out_key, ek);
        check({tag, ".err"}, out_err, ee);
        xfers++;
        @(negedge clk);
        check({tag, ".done_valid"}, out_valid, 1'b0);
        check({tag, ".done_busy"}, busy, 1'b0);
        check({tag, ".held_data"}, out_data, ed);
        check({tag, ".word_cnt"}, word_cnt, wc_exp());
    endtask

    task automatic load_seed(input logic [7:0] s);
        @(negedge clk);
        seed      = s;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        seed_load = 1'b0;
        seed      = '0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b1;

        // Reset state
        #3;
        check("rst.in_ready", in_ready, 1'b1);
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_data", out_data, 9'h000);
        check("rst.out_key", out_key, 8'h00);
        check("rst.out_err", out_err, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.word_cnt", word_cnt, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Seed, then encode (the second word uses the stepped key)
        load_seed(8'h5A);
        xfer(1'b0, 9'h0F0, 8'h00, 9'h14A, 8'h5A, 1'b0, "enc0");
        xfer(1'b0, 9'h001, 8'h00, 9'h02E, 8'h2D, 1'b0, "enc1");

        // Decode (no borrow, then borrow). The LFSR must not step.
        xfer(1'b1, 9'h14A, 8'h5A, 9'h0F0, 8'h5A, 1'b0, "dec0");
        xfer(1'b1, 9'h010, 8'h20, 9'h1F0, 8'h20, 1'b1, "dec1");
        xfer(1'b0, 9'h000, 8'h00, 9'h0AE, 8'hAE, 1'b0, "enc_after_dec");

        // A zero seed loads 1, and one free-run step gives B8.
        load_seed(8'h00);
        xfer(1'b0, 9'h000, 8'h00, 9'h001, 8'h01, 1'b0, "zero_seed");
        load_seed(8'h00);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        xfer(1'b0, 9'h010, 8'h00, 9'h0C8, 8'hB8, 1'b0, "free_run");

        // seed_load wins over in_valid in IDLE
        @(negedge clk);
        seed      = 8'h33;
        seed_load = 1'b1;
        in_data   = 9'h0FF;
        mode      = 1'b0;
        in_valid  = 1'b1;
        #1;
        check("prio.in_ready", in_ready, 1'b0);
        @(negedge clk);
        seed_load = 1'b0;
        in_valid  = 1'b0;
        check("prio.no_accept", busy, 1'b0);
        xfer(1'b0, 9'h000, 8'h00, 9'h033, 8'h33, 1'b0, "prio_enc");

        // Backpressure: the MSB of in_data is ignored, and a seed_load
        // during HOLD does not disturb the held word.
        out_ready = 1'b0;
        @(negedge clk);
        mode     = 1'b0;
        in_data  = 9'h105;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp.out_valid", out_valid, 1'b1);
            check("bp.out_data", out_data, 9'h0A6);
            check("bp.out_key", out_key, 8'hA1);
            check("bp.in_ready", in_ready, 1'b0);
            check("bp.busy", busy, 1'b1);
            if (i == 2) begin
                seed      = 8'h77;
                seed_load = 1'b1;
            end else begin
                seed_load = 1'b0;
            end
            @(negedge clk);
        end
        seed_load = 1'b0;
        out_ready = 1'b1;
        xfers++;
        @(negedge clk);
        check("bp.release_valid", out_valid, 1'b0);
        check("bp.release_busy", busy, 1'b0);
        check("bp.word_cnt", word_cnt, wc_exp());
        xfer(1'b0, 9'h000, 8'h00, 9'h077, 8'h77, 1'b0, "reseed_hold");

        // Asynchronous reset during CALC
        @(negedge clk);
        mode     = 1'b0;
        in_data  = 9'h0AA;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rmid.in_calc", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        xfers = 0;
        #1;
        check("rmid.out_valid", out_valid, 1'b0);
        check("rmid.busy", busy, 1'b0);
        check("rmid.out_data", out_data, 9'h000);
        check("rmid.out_key", out_key, 8'h00);
        check("rmid.word_cnt", word_cnt, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rmid.no_output", out_valid, 1'b0);
        end
        xfer(1'b0, 9'h002, 8'h00, 9'h003, 8'h01, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
